// File: rtl/logic_pkg.sv
// Shared definitions for the slice-serial logic unit: op encodings and FSM states.
package logic_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise op selector.
module logic_slice
   import logic_pkg::*;
#(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic [1:0]       op,
   output logic [SLICE-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         default: y = ~(a | b);
      endcase
   end

endmodule

// File: rtl/logic_unit_seq.sv
// Slice-serial bitwise logic unit: latches operands, emits SLICE result bits per
// cycle, then holds result and zero flag until the consumer takes them.
module logic_unit_seq
   import logic_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   generate
      if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_param
         $error("logic_unit_seq: WIDTH must be a positive multiple of SLICE");
      end
   endgenerate

   state_t                        state;
   logic [CW-1:0]                 cnt;
   logic [1:0]                    op_q;
   logic [NSLICE-1:0][SLICE-1:0]  a_q, b_q, res_q;
   logic                          acc;
   logic [SLICE-1:0]              y;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign result    = res_q;

   logic_slice #(.SLICE(SLICE)) u_slice (
      .a  (a_q[cnt]),
      .b  (b_q[cnt]),
      .op (op_q),
      .y  (y)
   );

   // acc collects "any bit set" so the zero flag needs no wide reduction of result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         acc   <= 1'b0;
         zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q   <= a;
               b_q   <= b;
               op_q  <= op;
               cnt   <= '0;
               res_q <= '0;
               acc   <= 1'b0;
               state <= RUN;
            end
            RUN: begin
               res_q[cnt] <= y;
               acc        <= acc | (|y);
               if (cnt == CW'(NSLICE - 1)) begin
                  zero  <= ~(acc | (|y));
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Randomized bench for logic_unit_seq at SLICE=8, 32 and 1 against a whole-word model.
module tb_logic_unit_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid [3];
   logic        in_ready [3];
   logic [1:0]  op       [3];
   logic [31:0] a        [3];
   logic [31:0] b        [3];
   logic        out_valid[3];
   logic        out_ready[3];
   logic [31:0] result   [3];
   logic        zero     [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   generate
      for (genvar k = 0; k < 3; k++) begin : g_dut
         localparam int SL = (k == 0) ? 8 : ((k == 1) ? 32 : 1);
         logic_unit_seq #(.WIDTH(32), .SLICE(SL)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .op        (op[k]),
            .a         (a[k]),
            .b         (b[k]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .result    (result[k]),
            .zero      (zero[k])
         );
      end
   endgenerate

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      case (o)
         2'b00:   return x & y;
         2'b01:   return x | y;
         2'b10:   return x ^ y;
         default: return ~(x | y);
      endcase
   endfunction

   function automatic int nsl(input int k);
      return (k == 0) ? 4 : ((k == 1) ? 1 : 32);
   endfunction

   // One full transaction: accept, wait for result, optionally stall in DONE, drain.
   task automatic do_op(input int k, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int hold);
      logic [31:0] er;
      logic        ez;
      int          lat;
      er = model(o, av, bv);
      ez = (er == 32'd0);
      @(negedge clk);
      check($sformatf("d%0d accept_ready", k), 32'(in_ready[k]), 32'd1);
      in_valid[k]  = 1'b1;
      op[k]        = o;
      a[k]         = av;
      b[k]         = bv;
      out_ready[k] = 1'b0;
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
      a[k]        = $urandom;
      b[k]        = $urandom;
      op[k]       = 2'($urandom);
      lat = 0;
      while (lat < 80) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid[k]) break;
      end
      check($sformatf("d%0d latency", k), 32'(lat), 32'(nsl(k)));
      check($sformatf("d%0d result op%0d", k, o), result[k], er);
      check($sformatf("d%0d zero", k), 32'(zero[k]), 32'(ez));
      for (int i = 0; i < hold; i++) begin
         in_valid[k] = ~in_valid[k];
         a[k]        = $urandom;
         b[k]        = $urandom;
         @(negedge clk);
         check($sformatf("d%0d hold_result", k), result[k], er);
         check($sformatf("d%0d hold_zero", k), 32'(zero[k]), 32'(ez));
         check($sformatf("d%0d hold_in_ready", k), 32'(in_ready[k]), 32'd0);
         check($sformatf("d%0d hold_out_valid", k), 32'(out_valid[k]), 32'd1);
      end
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[k] = 1'b0;
      @(negedge clk);
      check($sformatf("d%0d drain_in_ready", k), 32'(in_ready[k]), 32'd1);
      check($sformatf("d%0d drain_out_valid", k), 32'(out_valid[k]), 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 1'b0; op[k] = 2'b00; a[k] = '0; b[k] = '0; out_ready[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("d%0d rst_in_ready", k), 32'(in_ready[k]), 32'd1);
         check($sformatf("d%0d rst_out_valid", k), 32'(out_valid[k]), 32'd0);
         check($sformatf("d%0d rst_result", k), result[k], 32'd0);
         check($sformatf("d%0d rst_zero", k), 32'(zero[k]), 32'd0);
      end
      rst_n = 1'b1;

      do_op(0, 2'b01, 32'h0F0F0000, 32'h00F000FF, 0);
      do_op(0, 2'b11, 32'hFFFFFFFF, 32'h00000000, 0);
      do_op(0, 2'b10, 32'h12345678, 32'h12345678, 0);
      do_op(0, 2'b00, 32'hFFFF0000, 32'h00FFFF00, 5);

      // Reset in the middle of a computation after two slices are written.
      @(negedge clk);
      in_valid[0] = 1'b1; op[0] = 2'b01; a[0] = 32'hFFFFFFFF; b[0] = 32'h0;
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("midrun_out_valid", 32'(out_valid[0]), 32'd0);
      check("midrun_result", result[0], 32'd0);
      check("midrun_zero", 32'(zero[0]), 32'd0);
      check("midrun_in_ready", 32'(in_ready[0]), 32'd1);
      do_op(0, 2'b01, 32'h00000001, 32'h80000000, 0);

      do_op(1, 2'b00, 32'hA5A5A5A5, 32'hA5A5A5A5, 2);
      do_op(2, 2'b10, 32'hDEADBEEF, 32'h0F0F0F0F, 1);

      for (int n = 0; n < 24; n++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ~ra;
            default: rb = $urandom;
         endcase
         do_op(n % 3, 2'($urandom), ra, rb, int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
